icb_arb2: RTL and testbench
===========================

ICB_ARB2 -- requirements
Module: icb_arb2

Interface
REQ-001 SHALL have parameter AW, default 32, ICB address width.
REQ-002 SHALL have parameter DW, default 32, ICB data width; wmask width is DW/8.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports mN_icb_cmd_valid/read (in, 1), mN_icb_cmd_addr (in, AW), mN_icb_cmd_wdata (in, DW), mN_icb_cmd_wmask (in, DW/8), mN_icb_cmd_ready (out, 1), for N = 0, 1; master-side command channels.
REQ-006 SHALL have ports mN_icb_rsp_valid (out, 1), mN_icb_rsp_rdata (out, DW), mN_icb_rsp_err (out, 1), mN_icb_rsp_ready (in, 1), for N = 0, 1; master-side response channels.
REQ-007 SHALL have ports s_icb_cmd_valid/read/addr/wdata/wmask (out), s_icb_cmd_ready (in), s_icb_rsp_valid/rdata/err (in), s_icb_rsp_ready (out); single shared slave port (adder register block).
REQ-008 SHALL have port grant  output  2  one-hot owner of the slave port; 2'b00 when idle.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, CMD, RSP.
REQ-011 IDLE: if any mN_icb_cmd_valid, SHALL latch the winner into grant and go to CMD next cycle; else stay IDLE.
REQ-012 Only one master valid: that master SHALL win regardless of priority pointer.
REQ-013 Both valid: master indicated by round-robin pointer prio SHALL win.
REQ-014 CMD: s_icb_cmd_* SHALL be combinationally driven from the granted master; granted mN_icb_cmd_ready = s_icb_cmd_ready.
REQ-015 CMD: on s_icb_cmd_valid & s_icb_cmd_ready SHALL go to RSP.
REQ-016 CMD: if granted master deasserts cmd_valid before handshake, SHALL return to IDLE, clear grant, leave prio unchanged.
REQ-017 RSP: s_icb_rsp_valid/rdata/err SHALL route to granted master only; s_icb_rsp_ready = granted mN_icb_rsp_ready.
REQ-018 RSP: on s_icb_rsp_valid & s_icb_rsp_ready SHALL go to IDLE, clear grant, set prio to the non-served master.
REQ-019 Non-granted master SHALL see cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 at all times.
REQ-020 Outside CMD, s_icb_cmd_valid SHALL be 0 and s_icb_cmd_addr/wdata/wmask/read SHALL be 0; outside RSP, s_icb_rsp_ready SHALL be 0.
REQ-021 At most one transaction outstanding on the slave port; arbitration overhead exactly 1 cycle (IDLE) per transaction.
REQ-022 New request arriving while busy SHALL wait (no ready) until arbitration in a later IDLE cycle; no request dropped.
REQ-023 Back-to-back requests from both masters SHALL alternate strictly m0, m1, m0, ...

Reset
REQ-024 On rst_n low: state=IDLE, grant=2'b00, busy=0, prio=m0, all ready/valid outputs 0, immediately (asynchronous).
REQ-025 Reset mid-transaction SHALL abandon it; no response delivered after reset release.

Structure
REQ-026 State encoding (IDLE/CMD/RSP) and default AW/DW SHALL live in shared package icb_arb_pkg.
REQ-027 Round-robin winner/pointer logic SHALL be sub-module rr_arb2 (inputs req[1:0], prio; output one-hot gnt).
REQ-028 Datapath muxes SHALL be combinational; only state, grant, prio are registered.

Verification
REQ-029 Only m0 writes addr 0x000 data 0x0000_0005 -> grant=01 one cycle after valid, slave sees write, m0 gets rsp_valid with err=0; m1 sees no ready/valid.
REQ-030 m0 and m1 valid same cycle after reset (m0 write 0x000=3, m1 write 0x004=4) -> m0 served first, then m1; slave SUM readback by m0 at 0x00C = 7.
REQ-031 Both masters hold continuous read requests for 6 transactions -> grant sequence 01,10,01,10,01,10; each rdata delivered only to requester.
REQ-032 m1 holds rsp_ready=0 for 5 cycles in RSP -> busy stays 1, s_icb_rsp_ready=0, m0 request stalls, completes after m1 accepts.
REQ-033 m0 drops cmd_valid in CMD before slave ready -> state IDLE next cycle, grant=00, prio still m0.
REQ-034 rst_n asserted in RSP -> all outputs 0 same cycle; after release, first request arbitrates with prio=m0.

Source files
------------

// File: rtl/icb_arb_pkg.sv
// Shared definitions for the two-master ICB arbiter: FSM state encoding and
// default bus widths.
package icb_arb_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection. A lone requester always wins; when
// both request, prio picks the winner (0 = m0, 1 = m1).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // Pick a one-hot winner from the request pair.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/icb_arb2.sv
// Two-master to one-slave ICB arbiter. One transaction at a time owns the
// slave port; every transaction spends exactly one IDLE cycle in arbitration.
module icb_arb2
    import icb_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_icb_cmd_valid,
    input  logic            m0_icb_cmd_read,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    output logic            m0_icb_cmd_ready,
    output logic            m0_icb_rsp_valid,
    output logic [DW-1:0]   m0_icb_rsp_rdata,
    output logic            m0_icb_rsp_err,
    input  logic            m0_icb_rsp_ready,

    input  logic            m1_icb_cmd_valid,
    input  logic            m1_icb_cmd_read,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    output logic            m1_icb_cmd_ready,
    output logic            m1_icb_rsp_valid,
    output logic [DW-1:0]   m1_icb_rsp_rdata,
    output logic            m1_icb_rsp_err,
    input  logic            m1_icb_rsp_ready,

    output logic            s_icb_cmd_valid,
    output logic            s_icb_cmd_read,
    output logic [AW-1:0]   s_icb_cmd_addr,
    output logic [DW-1:0]   s_icb_cmd_wdata,
    output logic [DW/8-1:0] s_icb_cmd_wmask,
    input  logic            s_icb_cmd_ready,
    input  logic            s_icb_rsp_valid,
    input  logic [DW-1:0]   s_icb_rsp_rdata,
    input  logic            s_icb_rsp_err,
    output logic            s_icb_rsp_ready,

    output logic [1:0]      grant,
    output logic            busy
);

    arb_state_t state, state_nxt;
    logic [1:0] grant_nxt;
    logic       prio, prio_nxt;
    logic [1:0] arb_gnt;
    logic       sel;
    logic       sel_cmd_valid;
    logic       sel_rsp_ready;

    rr_arb2 u_rr_arb2 (
        .req  ({m1_icb_cmd_valid, m0_icb_cmd_valid}),
        .prio (prio),
        .gnt  (arb_gnt)
    );

    // sel is 1 when m1 owns the slave port; only meaningful while grant is set.
    assign sel           = grant[1];
    assign sel_cmd_valid = sel ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    assign sel_rsp_ready = sel ? m1_icb_rsp_ready : m0_icb_rsp_ready;
    assign busy          = (state != IDLE);

    // State, owner and round-robin pointer registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 2'b00;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            prio  <= prio_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, follow the command and response handshakes.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        prio_nxt  = prio;
        case (state)
            IDLE: begin
                if (m0_icb_cmd_valid || m1_icb_cmd_valid) begin
                    grant_nxt = arb_gnt;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (!sel_cmd_valid) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                end else if (s_icb_cmd_ready) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (s_icb_rsp_valid && sel_rsp_ready) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    prio_nxt  = grant[0];
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    // Routing muxes: connect the owner to the slave, hold everyone else at zero.
    always_comb begin
        s_icb_cmd_valid  = 1'b0;
        s_icb_cmd_read   = 1'b0;
        s_icb_cmd_addr   = '0;
        s_icb_cmd_wdata  = '0;
        s_icb_cmd_wmask  = '0;
        s_icb_rsp_ready  = 1'b0;
        m0_icb_cmd_ready = 1'b0;
        m1_icb_cmd_ready = 1'b0;
        m0_icb_rsp_valid = 1'b0;
        m0_icb_rsp_rdata = '0;
        m0_icb_rsp_err   = 1'b0;
        m1_icb_rsp_valid = 1'b0;
        m1_icb_rsp_rdata = '0;
        m1_icb_rsp_err   = 1'b0;
        if (state == CMD) begin
            s_icb_cmd_valid  = sel_cmd_valid;
            s_icb_cmd_read   = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
            s_icb_cmd_addr   = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
            s_icb_cmd_wdata  = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
            s_icb_cmd_wmask  = sel ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
            m0_icb_cmd_ready = grant[0] & s_icb_cmd_ready;
            m1_icb_cmd_ready = grant[1] & s_icb_cmd_ready;
        end
        if (state == RSP) begin
            s_icb_rsp_ready = sel_rsp_ready;
            if (grant[0]) begin
                m0_icb_rsp_valid = s_icb_rsp_valid;
                m0_icb_rsp_rdata = s_icb_rsp_rdata;
                m0_icb_rsp_err   = s_icb_rsp_err;
            end
            if (grant[1]) begin
                m1_icb_rsp_valid = s_icb_rsp_valid;
                m1_icb_rsp_rdata = s_icb_rsp_rdata;
                m1_icb_rsp_err   = s_icb_rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_icb_arb2.sv
// Self-checking bench for icb_arb2: drives both masters with directed
// transactions against a small adder register slave (A at 0x0, B at 0x4,
// read-only SUM at 0xC) and compares every cycle against a transaction model.
module tb_icb_arb2;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst_n;

    logic [1:0]          m_valid;
    logic [1:0]          m_read;
    logic [1:0][AW-1:0]  m_addr;
    logic [1:0][DW-1:0]  m_wdata;
    logic [1:0][3:0]     m_wmask;
    logic [1:0]          m_rsp_ready;

    logic [1:0]          cmd_ready_o;
    logic [1:0]          rsp_valid_o;
    logic [1:0]          rsp_err_o;
    logic [1:0][DW-1:0]  rsp_rdata_o;

    logic                s_cmd_valid;
    logic                s_cmd_read;
    logic [AW-1:0]       s_cmd_addr;
    logic [DW-1:0]       s_cmd_wdata;
    logic [3:0]          s_cmd_wmask;
    logic                s_cmd_ready;
    logic                s_rsp_valid;
    logic [DW-1:0]       s_rsp_rdata;
    logic                s_rsp_err;
    logic                s_rsp_ready;

    logic [1:0]          grant;
    logic                busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] reg_a, reg_b;

    int         own;
    bit         issued;
    int         mprio;
    logic [1:0] prev_grant;
    bit         rec_en;
    logic [1:0] grant_log[$];

    icb_arb2 #(.AW(AW), .DW(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0_icb_cmd_valid (m_valid[0]),
        .m0_icb_cmd_read  (m_read[0]),
        .m0_icb_cmd_addr  (m_addr[0]),
        .m0_icb_cmd_wdata (m_wdata[0]),
        .m0_icb_cmd_wmask (m_wmask[0]),
        .m0_icb_cmd_ready (cmd_ready_o[0]),
        .m0_icb_rsp_valid (rsp_valid_o[0]),
        .m0_icb_rsp_rdata (rsp_rdata_o[0]),
        .m0_icb_rsp_err   (rsp_err_o[0]),
        .m0_icb_rsp_ready (m_rsp_ready[0]),
        .m1_icb_cmd_valid (m_valid[1]),
        .m1_icb_cmd_read  (m_read[1]),
        .m1_icb_cmd_addr  (m_addr[1]),
        .m1_icb_cmd_wdata (m_wdata[1]),
        .m1_icb_cmd_wmask (m_wmask[1]),
        .m1_icb_cmd_ready (cmd_ready_o[1]),
        .m1_icb_rsp_valid (rsp_valid_o[1]),
        .m1_icb_rsp_rdata (rsp_rdata_o[1]),
        .m1_icb_rsp_err   (rsp_err_o[1]),
        .m1_icb_rsp_ready (m_rsp_ready[1]),
        .s_icb_cmd_valid  (s_cmd_valid),
        .s_icb_cmd_read   (s_cmd_read),
        .s_icb_cmd_addr   (s_cmd_addr),
        .s_icb_cmd_wdata  (s_cmd_wdata),
        .s_icb_cmd_wmask  (s_cmd_wmask),
        .s_icb_cmd_ready  (s_cmd_ready),
        .s_icb_rsp_valid  (s_rsp_valid),
        .s_icb_rsp_rdata  (s_rsp_rdata),
        .s_icb_rsp_err    (s_rsp_err),
        .s_icb_rsp_ready  (s_rsp_ready),
        .grant            (grant),
        .busy             (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait somewhere is not bounded as intended.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Adder register slave: one-cycle registered response, held until accepted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rsp_valid <= 1'b0;
            s_rsp_rdata <= '0;
            s_rsp_err   <= 1'b0;
            reg_a       <= '0;
            reg_b       <= '0;
        end else begin
            if (s_rsp_valid && s_rsp_ready)
                s_rsp_valid <= 1'b0;
            if (s_cmd_valid && s_cmd_ready) begin
                s_rsp_valid <= 1'b1;
                s_rsp_rdata <= '0;
                s_rsp_err   <= 1'b0;
                if (s_cmd_read) begin
                    case (s_cmd_addr)
                        32'h000: s_rsp_rdata <= reg_a;
                        32'h004: s_rsp_rdata <= reg_b;
                        32'h00C: s_rsp_rdata <= reg_a + reg_b;
                        default: s_rsp_err   <= 1'b1;
                    endcase
                end else begin
                    case (s_cmd_addr)
                        32'h000: for (int b = 0; b < 4; b++)
                                     if (s_cmd_wmask[b]) reg_a[b*8 +: 8] <= s_cmd_wdata[b*8 +: 8];
                        32'h004: for (int b = 0; b < 4; b++)
                                     if (s_cmd_wmask[b]) reg_b[b*8 +: 8] <= s_cmd_wdata[b*8 +: 8];
                        default: s_rsp_err <= 1'b1;
                    endcase
                end
            end
        end
    end

    // Transaction model and per-cycle comparison. The model tracks who owns the
    // slave and whether its command has been accepted, then derives every
    // output from that; it advances on the handshakes seen this cycle.
    always @(negedge clk) begin
        int o;
        bit in_cmd, in_rsp;
        logic [1:0] exp_grant;
        if (!rst_n) begin
            own    = -1;
            issued = 0;
            mprio  = 0;
            checkOutput("reset_quiet",
                64'({grant, busy, cmd_ready_o, rsp_valid_o, s_cmd_valid, s_rsp_ready}), 64'd0);
        end else begin
            o         = (own < 0) ? 0 : own;
            in_cmd    = (own >= 0) && !issued;
            in_rsp    = (own >= 0) && issued;
            exp_grant = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
            checkOutput("grant", 64'(grant), 64'(exp_grant));
            checkOutput("busy", 64'(busy), 64'(own >= 0));
            checkOutput("s_cmd_valid", 64'(s_cmd_valid), 64'(in_cmd ? m_valid[o] : 1'b0));
            checkOutput("s_cmd_addr", 64'(s_cmd_addr), 64'(in_cmd ? m_addr[o] : 32'd0));
            checkOutput("s_cmd_wdata", 64'(s_cmd_wdata), 64'(in_cmd ? m_wdata[o] : 32'd0));
            checkOutput("s_cmd_rd_mask", 64'({s_cmd_read, s_cmd_wmask}),
                64'(in_cmd ? {m_read[o], m_wmask[o]} : 5'd0));
            checkOutput("s_rsp_ready", 64'(s_rsp_ready), 64'(in_rsp ? m_rsp_ready[o] : 1'b0));
            for (int n = 0; n < 2; n++) begin
                checkOutput($sformatf("m%0d_ctrl", n),
                    64'({cmd_ready_o[n], rsp_valid_o[n], rsp_err_o[n]}),
                    64'({(in_cmd && o == n) ? s_cmd_ready : 1'b0,
                         (in_rsp && o == n) ? s_rsp_valid : 1'b0,
                         (in_rsp && o == n) ? s_rsp_err   : 1'b0}));
                checkOutput($sformatf("m%0d_rdata", n), 64'(rsp_rdata_o[n]),
                    64'((in_rsp && o == n) ? s_rsp_rdata : 32'd0));
            end
            if (own < 0) begin
                if (m_valid != 2'b00) begin
                    own    = (m_valid == 2'b11) ? mprio : (m_valid[1] ? 1 : 0);
                    issued = 0;
                end
            end else if (!issued) begin
                if (!m_valid[o])
                    own = -1;
                else if (s_cmd_ready)
                    issued = 1;
            end else if (s_rsp_valid && m_rsp_ready[o]) begin
                mprio = 1 - o;
                own   = -1;
            end
        end
        if (rec_en && grant != 2'b00 && prev_grant == 2'b00)
            grant_log.push_back(grant);
        prev_grant = grant;
    end

    // One complete master transaction: present the command, drop it after the
    // handshake, then wait for and capture the response. Starts and ends 1
    // unit after a rising edge.
    task automatic applyStimulus(input int n, input bit rd, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err);
        int cnt;
        rdata      = '0;
        err        = 1'b0;
        m_valid[n] = 1'b1;
        m_read[n]  = rd;
        m_addr[n]  = addr;
        m_wdata[n] = wdata;
        m_wmask[n] = 4'hF;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!cmd_ready_o[n] && cnt < 100);
        if (!cmd_ready_o[n]) failNow($sformatf("m%0d_cmd_wait", n));
        @(posedge clk);
        #1;
        m_valid[n] = 1'b0;
        m_read[n]  = 1'b0;
        m_addr[n]  = '0;
        m_wdata[n] = '0;
        m_wmask[n] = '0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(rsp_valid_o[n] && m_rsp_ready[n]) && cnt < 100);
        if (!(rsp_valid_o[n] && m_rsp_ready[n])) begin
            failNow($sformatf("m%0d_rsp_wait", n));
        end else begin
            rdata = rsp_rdata_o[n];
            err   = rsp_err_o[n];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed scenario sequence.
    initial begin
        logic [31:0] rd0, rd1;
        logic        e0, e1;
        logic [31:0] r0q[3];
        logic [31:0] r1q[3];
        time         t0_done, t1_done;
        int          cnt;
        logic [1:0]  exp_seq[6];

        rst_n       = 1'b0;
        m_valid     = '0;
        m_read      = '0;
        m_addr      = '0;
        m_wdata     = '0;
        m_wmask     = '0;
        m_rsp_ready = 2'b11;
        s_cmd_ready = 1'b1;
        rec_en      = 0;
        prev_grant  = 2'b00;
        #1;
        checkOutput("reset_grant_busy", 64'({grant, busy}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Simultaneous writes straight after reset: m0 first, then m1; SUM = 3 + 4.
        grant_log.delete();
        rec_en = 1;
        fork
            applyStimulus(0, 1'b0, 32'h000, 32'd3, rd0, e0);
            applyStimulus(1, 1'b0, 32'h004, 32'd4, rd1, e1);
        join
        rec_en = 0;
        checkOutput("r030_len", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() >= 2) begin
            checkOutput("r030_first", 64'(grant_log[0]), 64'(2'b01));
            checkOutput("r030_second", 64'(grant_log[1]), 64'(2'b10));
        end
        checkOutput("r030_werr", 64'({e0, e1}), 64'd0);
        applyStimulus(0, 1'b1, 32'h00C, 32'd0, rd0, e0);
        checkOutput("r030_sum", 64'(rd0), 64'd7);
        checkOutput("r030_sum_err", 64'(e0), 64'd0);

        // Lone m0 write: grant rises one cycle after valid even though prio points at m1.
        fork
            applyStimulus(0, 1'b0, 32'h000, 32'd5, rd0, e0);
            begin
                @(negedge clk);
                checkOutput("r029_arb_cycle", 64'({grant, busy}), 64'd0);
                @(negedge clk);
                checkOutput("r029_grant", 64'(grant), 64'(2'b01));
            end
        join
        checkOutput("r029_err", 64'(e0), 64'd0);
        checkOutput("r029_slave_a", 64'(reg_a), 64'd5);

        // Lone m1 read of SUM (5 + 4); leaves the pointer at m0.
        applyStimulus(1, 1'b1, 32'h00C, 32'd0, rd1, e1);
        checkOutput("m1_sum", 64'(rd1), 64'd9);

        // Continuous reads from both masters must alternate strictly.
        grant_log.delete();
        rec_en = 1;
        fork
            for (int i = 0; i < 3; i++) begin
                logic [31:0] r;
                logic        e;
                applyStimulus(0, 1'b1, 32'h000, 32'd0, r, e);
                r0q[i] = r;
            end
            for (int i = 0; i < 3; i++) begin
                logic [31:0] r;
                logic        e;
                applyStimulus(1, 1'b1, 32'h004, 32'd0, r, e);
                r1q[i] = r;
            end
        join
        rec_en = 0;
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        checkOutput("r031_len", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size())
                checkOutput($sformatf("r031_grant%0d", i), 64'(grant_log[i]), 64'(exp_seq[i]));
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("r031_m0_rdata%0d", i), 64'(r0q[i]), 64'd5);
            checkOutput($sformatf("r031_m1_rdata%0d", i), 64'(r1q[i]), 64'd4);
        end

        // m0 withdraws its command while the slave is not ready.
        s_cmd_ready = 1'b0;
        m_valid[0]  = 1'b1;
        m_read[0]   = 1'b1;
        m_addr[0]   = 32'h000;
        m_wmask[0]  = 4'hF;
        @(negedge clk);
        checkOutput("r033_idle", 64'(grant), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("r033_cmd", 64'({grant, s_cmd_valid}), 64'({2'b01, 1'b1}));
        tick();
        m_valid[0] = 1'b0;
        m_read[0]  = 1'b0;
        m_addr[0]  = '0;
        m_wmask[0] = '0;
        tick();
        @(negedge clk);
        checkOutput("r033_back_idle", 64'({grant, busy}), 64'd0);
        tick();
        s_cmd_ready = 1'b1;
        grant_log.delete();
        rec_en = 1;
        fork
            applyStimulus(0, 1'b1, 32'h00C, 32'd0, rd0, e0);
            applyStimulus(1, 1'b1, 32'h010, 32'd0, rd1, e1);
        join
        rec_en = 0;
        if (grant_log.size() > 0)
            checkOutput("r033_prio_kept", 64'(grant_log[0]), 64'(2'b01));
        else
            failNow("r033_prio_kept");
        checkOutput("r033_m0_sum", 64'({e0, rd0}), 64'd9);
        checkOutput("r033_m1_err", 64'({e1, rd1}), 64'h1_0000_0000);

        // m1 stalls its response for 5 cycles while m0 waits behind it.
        m_rsp_ready[1] = 1'b0;
        fork
            begin
                applyStimulus(1, 1'b1, 32'h004, 32'd0, rd1, e1);
                t1_done = $time;
            end
            begin
                tick();
                tick();
                applyStimulus(0, 1'b1, 32'h000, 32'd0, rd0, e0);
                t0_done = $time;
            end
            begin
                cnt = 0;
                do begin
                    @(negedge clk);
                    cnt++;
                end while (!rsp_valid_o[1] && cnt < 100);
                if (!rsp_valid_o[1]) failNow("r032_rsp_wait");
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    checkOutput($sformatf("r032_stall%0d", i),
                        64'({busy, s_rsp_ready, cmd_ready_o[0]}), 64'(3'b100));
                end
                tick();
                m_rsp_ready[1] = 1'b1;
            end
        join
        checkOutput("r032_order", 64'(t0_done > t1_done), 64'd1);
        checkOutput("r032_rdata", 64'({rd1, rd0}), 64'({32'd4, 32'd5}));

        // Reset while m0 sits in RSP; afterwards prio must be back at m0.
        m_rsp_ready[0] = 1'b0;
        m_valid[0]     = 1'b1;
        m_read[0]      = 1'b1;
        m_addr[0]      = 32'h000;
        m_wmask[0]     = 4'hF;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!cmd_ready_o[0] && cnt < 100);
        if (!cmd_ready_o[0]) failNow("r034_cmd_wait");
        tick();
        m_valid[0] = 1'b0;
        m_read[0]  = 1'b0;
        m_addr[0]  = '0;
        m_wmask[0] = '0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!rsp_valid_o[0] && cnt < 100);
        if (!rsp_valid_o[0]) failNow("r034_rsp_wait");
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("r034_async",
            64'({grant, busy, cmd_ready_o, rsp_valid_o, s_cmd_valid, s_rsp_ready}), 64'd0);
        m_rsp_ready[0] = 1'b1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("r034_no_stale_rsp", 64'(rsp_valid_o), 64'd0);
        tick();
        grant_log.delete();
        rec_en = 1;
        fork
            applyStimulus(0, 1'b1, 32'h000, 32'd0, rd0, e0);
            applyStimulus(1, 1'b1, 32'h004, 32'd0, rd1, e1);
        join
        rec_en = 0;
        if (grant_log.size() > 0)
            checkOutput("r034_prio_reset", 64'(grant_log[0]), 64'(2'b01));
        else
            failNow("r034_prio_reset");
        checkOutput("r034_regs_cleared", 64'({rd1, rd0}), 64'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
